// File: rtl/ac97_codec_model.sv
// AC'97 codec stand-in: releases the bit clock after a cold reset, decodes controller
// frames (register access, playback PCM) and returns deterministic capture frames.
module ac97_codec_model #(
    parameter int          STARTUP_CYC = 64,
    parameter logic [15:0] RESET_ID    = 16'h0090,
    parameter logic [15:0] VENDOR_ID1  = 16'h4144,
    parameter logic [15:0] VENDOR_ID2  = 16'h5370
) (
    input  logic        sys13p5_clk,
    input  logic        rst_n,
    input  logic        flash_audio_reset_b,
    output logic        bit_clk_en,
    input  logic        audio_sync,
    input  logic        audio_sdata_out,
    output logic        audio_sdata_in,
    output logic        cmd_wr_stb,
    output logic [6:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic [19:0] pcm_left,
    output logic [19:0] pcm_right,
    output logic        pcm_stb,
    output logic [15:0] frame_cnt,
    output logic        sync_err
);

    localparam int              CNT_W       = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STARTUP_CYC - 1);
    localparam logic [15:0]     REG_DEFAULT = 16'h8000;

    typedef enum logic [1:0] {
        WAIT_RST,
        STARTUP,
        HUNT,
        IN_FRAME
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] start_cnt;
    logic [7:0]       bit_idx;
    logic             sync_prev;
    logic             rst_d1;
    logic             rst_d2;
    logic             rst_d3;
    logic             ris;

    logic [95:0]      rx_sh;
    logic             rsp_valid;
    logic [6:0]       rsp_addr;
    logic [15:0]      rsp_data;
    logic [19:0]      adc_cnt;
    logic [15:0]      regs [16];

    // Cold-reset request from the controller crosses in through a 3-flop chain
    always_ff @(posedge sys13p5_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_d1 <= 1'b0;
            rst_d2 <= 1'b0;
            rst_d3 <= 1'b0;
        end else begin
            rst_d1 <= flash_audio_reset_b;
            rst_d2 <= rst_d1;
            rst_d3 <= rst_d2;
        end
    end

    assign ris = rst_d2 & ~rst_d3;

    // Received frame fields; rx_sh[95] holds frame bit 0 once 96 bits are in
    logic        rx_valid;
    logic        rx_s1v;
    logic        rx_s2v;
    logic        rx_s3v;
    logic        rx_s4v;
    logic        rx_is_read;
    logic [6:0]  rx_addr;
    logic [15:0] rx_data;
    logic [19:0] rx_left;
    logic [19:0] rx_right;
    logic        rx_in_file;

    assign rx_valid   = rx_sh[95];
    assign rx_s1v     = rx_sh[94];
    assign rx_s2v     = rx_sh[93];
    assign rx_s3v     = rx_sh[92];
    assign rx_s4v     = rx_sh[91];
    assign rx_is_read = rx_sh[79];
    assign rx_addr    = rx_sh[78:72];
    assign rx_data    = rx_sh[59:44];
    assign rx_left    = rx_sh[39:20];
    assign rx_right   = rx_sh[19:0];
    assign rx_in_file = !rx_addr[0] && (rx_addr <= 7'h1E);

    logic [15:0] rd_data;

    always_comb begin
        rd_data = 16'h0000;
        if (rx_in_file) begin
            rd_data = (rx_addr == 7'h00) ? RESET_ID : regs[rx_addr[4:1]];
        end else if (rx_addr == 7'h26) begin
            rd_data = 16'h000F;
        end else if (rx_addr == 7'h7C) begin
            rd_data = VENDOR_ID1;
        end else if (rx_addr == 7'h7E) begin
            rd_data = VENDOR_ID2;
        end
    end

    // First 96 outgoing bits (tag + slots 1..4); the remaining slots are always zero
    logic [15:0] tx_tag;
    logic [19:0] tx_slot1;
    logic [19:0] tx_slot2;
    logic [95:0] tx_vec;
    logic [7:0]  next_idx;
    logic        tx_next;
    logic        sync_expect;

    always_comb begin
        tx_tag   = rsp_valid ? 16'hF800 : 16'h9800;
        tx_slot1 = rsp_valid ? {1'b0, rsp_addr, 12'h000} : 20'h00000;
        tx_slot2 = rsp_valid ? {rsp_data, 4'h0} : 20'h00000;
        tx_vec   = {tx_tag, tx_slot1, tx_slot2, adc_cnt, ~adc_cnt};
        next_idx = bit_idx + 8'd1;
        tx_next  = 1'b0;
        if (next_idx < 8'd96) begin
            tx_next = tx_vec[7'd95 - next_idx[6:0]];
        end
        sync_expect = (bit_idx < 8'd15) || (bit_idx == 8'd255);
    end

    // Link state machine with frame decode; a cold reset overrides every state
    always_ff @(posedge sys13p5_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= WAIT_RST;
            start_cnt      <= '0;
            bit_idx        <= '0;
            sync_prev      <= 1'b0;
            rx_sh          <= '0;
            rsp_valid      <= 1'b0;
            rsp_addr       <= '0;
            rsp_data       <= '0;
            adc_cnt        <= '0;
            bit_clk_en     <= 1'b0;
            audio_sdata_in <= 1'b0;
            cmd_wr_stb     <= 1'b0;
            cmd_addr       <= '0;
            cmd_data       <= '0;
            pcm_left       <= '0;
            pcm_right      <= '0;
            pcm_stb        <= 1'b0;
            frame_cnt      <= '0;
            sync_err       <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                regs[k] <= REG_DEFAULT;
            end
        end else begin
            cmd_wr_stb <= 1'b0;
            pcm_stb    <= 1'b0;
            sync_prev  <= audio_sync;

            if (!rst_d2) begin
                state          <= WAIT_RST;
                start_cnt      <= '0;
                bit_clk_en     <= 1'b0;
                audio_sdata_in <= 1'b0;
                rsp_valid      <= 1'b0;
                adc_cnt        <= '0;
                frame_cnt      <= '0;
                for (int k = 0; k < 16; k++) begin
                    regs[k] <= REG_DEFAULT;
                end
            end else begin
                case (state)
                    WAIT_RST: begin
                        audio_sdata_in <= 1'b0;
                        if (ris) begin
                            state     <= STARTUP;
                            start_cnt <= '0;
                        end
                    end

                    STARTUP: begin
                        audio_sdata_in <= 1'b0;
                        if (start_cnt == CNT_LAST) begin
                            state      <= HUNT;
                            bit_clk_en <= 1'b1;
                        end else begin
                            start_cnt <= start_cnt + 1'b1;
                        end
                    end

                    HUNT: begin
                        audio_sdata_in <= 1'b0;
                        rsp_valid      <= 1'b0;
                        if (audio_sync && !sync_prev) begin
                            state          <= IN_FRAME;
                            bit_idx        <= 8'd0;
                            audio_sdata_in <= tx_vec[95];
                        end
                    end

                    IN_FRAME: begin
                        if (audio_sync != sync_expect) begin
                            state          <= HUNT;
                            sync_err       <= 1'b1;
                            audio_sdata_in <= 1'b0;
                            rsp_valid      <= 1'b0;
                        end else begin
                            bit_idx        <= next_idx;
                            audio_sdata_in <= tx_next;
                            if (bit_idx < 8'd96) begin
                                rx_sh <= {rx_sh[94:0], audio_sdata_out};
                            end
                            // Frame end: commit everything collected in this frame at once
                            if (bit_idx == 8'd255) begin
                                frame_cnt <= frame_cnt + 16'd1;
                                adc_cnt   <= adc_cnt + 20'd1;

                                if (rx_valid && rx_s1v && rx_s2v && !rx_is_read) begin
                                    cmd_wr_stb <= 1'b1;
                                    cmd_addr   <= rx_addr;
                                    cmd_data   <= rx_data;
                                    if (rx_addr == 7'h00) begin
                                        for (int k = 0; k < 16; k++) begin
                                            regs[k] <= REG_DEFAULT;
                                        end
                                    end else if (rx_in_file) begin
                                        regs[rx_addr[4:1]] <= rx_data;
                                    end
                                end

                                rsp_valid <= rx_valid && rx_s1v && rx_is_read;
                                rsp_addr  <= rx_addr;
                                rsp_data  <= rd_data;

                                if (rx_valid && (rx_s3v || rx_s4v)) begin
                                    pcm_stb <= 1'b1;
                                    if (rx_s3v) begin
                                        pcm_left <= rx_left;
                                    end
                                    if (rx_s4v) begin
                                        pcm_right <= rx_right;
                                    end
                                end
                            end
                        end
                    end

                    default: state <= WAIT_RST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ac97_codec_model.sv
// Directed bench for ac97_codec_model: drives AC'97 frames bit by bit and checks
// clock release timing, register access, PCM capture, framing errors and cold reset.
module tb_ac97_codec_model;

    logic        sys13p5_clk = 1'b0;
    logic        rst_n;
    logic        flash_audio_reset_b;
    logic        audio_sync;
    logic        audio_sdata_out;
    logic        bit_clk_en;
    logic        audio_sdata_in;
    logic        cmd_wr_stb;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [19:0] pcm_left;
    logic [19:0] pcm_right;
    logic        pcm_stb;
    logic [15:0] frame_cnt;
    logic        sync_err;

    int          checks    = 0;
    int          failures  = 0;
    int          wrStbCnt  = 0;
    int          pcmStbCnt = 0;
    logic [95:0] txCap     = '0;

    ac97_codec_model dut (
        .sys13p5_clk         (sys13p5_clk),
        .rst_n               (rst_n),
        .flash_audio_reset_b (flash_audio_reset_b),
        .bit_clk_en          (bit_clk_en),
        .audio_sync          (audio_sync),
        .audio_sdata_out     (audio_sdata_out),
        .audio_sdata_in      (audio_sdata_in),
        .cmd_wr_stb          (cmd_wr_stb),
        .cmd_addr            (cmd_addr),
        .cmd_data            (cmd_data),
        .pcm_left            (pcm_left),
        .pcm_right           (pcm_right),
        .pcm_stb             (pcm_stb),
        .frame_cnt           (frame_cnt),
        .sync_err            (sync_err)
    );

    always #37 sys13p5_clk = ~sys13p5_clk;

    // A strobe held for more than one cycle counts more than once
    always @(negedge sys13p5_clk) begin
        if (cmd_wr_stb) wrStbCnt++;
        if (pcm_stb) pcmStbCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [95:0] mkFrame(input logic [15:0] tag, input logic [19:0] s1,
                                            input logic [19:0] s2, input logic [19:0] s3,
                                            input logic [19:0] s4);
        return {tag, s1, s2, s3, s4};
    endfunction

    // Step k drives the sample at posedge t0+k and captures outgoing bit k-1
    task automatic applyStimulus(input logic [95:0] frm, input int syncLast, input int nBits);
        for (int k = 0; k < nBits; k++) begin
            @(negedge sys13p5_clk);
            if (k >= 1 && k <= 96) txCap[96-k] = audio_sdata_in;
            audio_sync      = (k < 16) && (k <= syncLast);
            audio_sdata_out = (k >= 1 && k <= 96) ? frm[96-k] : 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys13p5_clk);
            audio_sync      = 1'b0;
            audio_sdata_out = 1'b0;
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        flash_audio_reset_b = 1'b0;
        audio_sync          = 1'b0;
        audio_sdata_out     = 1'b0;
        repeat (3) @(negedge sys13p5_clk);
        checkOutput("rst_bit_clk_en", bit_clk_en, 0);
        checkOutput("rst_sdata_in", audio_sdata_in, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        checkOutput("rst_sync_err", sync_err, 0);
        checkOutput("rst_cmd_addr", cmd_addr, 0);
        checkOutput("rst_pcm_left", pcm_left, 0);

        rst_n = 1'b1;
        repeat (4) @(negedge sys13p5_clk);
        flash_audio_reset_b = 1'b1;
        repeat (66) @(posedge sys13p5_clk);
        @(negedge sys13p5_clk);
        checkOutput("clk_en_before_67", bit_clk_en, 0);
        @(posedge sys13p5_clk);
        @(negedge sys13p5_clk);
        checkOutput("clk_en_at_67", bit_clk_en, 1);
        idleCycles(5);
        checkOutput("sdata_in_hunt", audio_sdata_in, 0);

        // Write 0x18 = 0x0808
        applyStimulus(mkFrame(16'hE000, 20'h18000, 20'h08080, 20'h0, 20'h0), 255, 256);
        checkOutput("f1_tag", txCap[95:80], 16'h9800);
        checkOutput("f1_slot1", txCap[79:60], 20'h00000);
        checkOutput("f1_slot3", txCap[39:20], 20'h00000);
        checkOutput("f1_slot4", txCap[19:0], 20'hFFFFF);

        // Read 0x18
        applyStimulus(mkFrame(16'hC000, 20'h98000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("wr_stb_count", wrStbCnt, 1);
        checkOutput("wr_addr", cmd_addr, 7'h18);
        checkOutput("wr_data", cmd_data, 16'h0808);
        checkOutput("f2_tag", txCap[95:80], 16'h9800);
        checkOutput("f2_slot3", txCap[39:20], 20'h00001);

        // Read 0x7C
        applyStimulus(mkFrame(16'hC000, 20'hFC000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("rd18_tag", txCap[95:80], 16'hF800);
        checkOutput("rd18_slot1", txCap[79:60], 20'h18000);
        checkOutput("rd18_slot2", txCap[59:40], 20'h08080);
        checkOutput("f3_slot3", txCap[39:20], 20'h00002);
        checkOutput("f3_slot4", txCap[19:0], 20'hFFFFD);

        // Read 0x26
        applyStimulus(mkFrame(16'hC000, 20'hA6000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("rd7c_slot1", txCap[79:60], 20'h7C000);
        checkOutput("rd7c_slot2", txCap[59:40], 20'h41440);
        checkOutput("f4_slot3", txCap[39:20], 20'h00003);

        // Read 0x05
        applyStimulus(mkFrame(16'hC000, 20'h85000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("rd26_slot2", txCap[59:40], 20'h000F0);

        // PCM on both channels
        applyStimulus(mkFrame(16'h9800, 20'h0, 20'h0, 20'h12345, 20'hABCDE), 255, 256);
        checkOutput("rd05_tag", txCap[95:80], 16'hF800);
        checkOutput("rd05_slot1", txCap[79:60], 20'h05000);
        checkOutput("rd05_slot2", txCap[59:40], 20'h00000);
        checkOutput("reads_no_wr_stb", wrStbCnt, 1);

        // PCM on left only
        applyStimulus(mkFrame(16'h9000, 20'h0, 20'h0, 20'h54321, 20'h11111), 255, 256);
        checkOutput("pcm_stb_count1", pcmStbCnt, 1);
        checkOutput("pcm_left1", pcm_left, 20'h12345);
        checkOutput("pcm_right1", pcm_right, 20'hABCDE);
        checkOutput("f7_tag", txCap[95:80], 16'h9800);
        checkOutput("f7_slot3", txCap[39:20], 20'h00006);
        checkOutput("f7_slot4", txCap[19:0], 20'hFFFF9);

        // Invalid frame
        applyStimulus(mkFrame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("pcm_stb_count2", pcmStbCnt, 2);
        checkOutput("pcm_left2", pcm_left, 20'h54321);
        checkOutput("pcm_right2", pcm_right, 20'hABCDE);
        checkOutput("frame_cnt7", frame_cnt, 7);
        checkOutput("sync_err_clean", sync_err, 0);

        // Write frame with sync dropped at sample 5
        applyStimulus(mkFrame(16'hE800, 20'h02000, 20'h12340, 20'h77777, 20'h0), 5, 256);
        checkOutput("drop_sync_err", sync_err, 1);
        checkOutput("drop_frame_cnt", frame_cnt, 8);
        checkOutput("drop_no_wr_stb", wrStbCnt, 1);
        checkOutput("drop_no_pcm_stb", pcmStbCnt, 2);

        applyStimulus(mkFrame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("relock_tag", txCap[95:80], 16'h9800);
        checkOutput("relock_slot3", txCap[39:20], 20'h00008);
        applyStimulus(mkFrame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("relock_frame_cnt", frame_cnt, 9);

        // Write 0x18 again, then cold reset in the middle of the next frame
        applyStimulus(mkFrame(16'hE000, 20'h18000, 20'h08080, 20'h0, 20'h0), 255, 256);
        applyStimulus(mkFrame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0), 255, 100);
        checkOutput("cold_pre_wr_stb", wrStbCnt, 2);
        checkOutput("cold_pre_frame_cnt", frame_cnt, 11);
        @(negedge sys13p5_clk);
        flash_audio_reset_b = 1'b0;
        audio_sync          = 1'b0;
        audio_sdata_out     = 1'b0;
        repeat (3) @(posedge sys13p5_clk);
        @(negedge sys13p5_clk);
        checkOutput("cold_bit_clk_en", bit_clk_en, 0);
        checkOutput("cold_frame_cnt", frame_cnt, 0);
        checkOutput("cold_sdata_in", audio_sdata_in, 0);
        checkOutput("cold_sync_err_held", sync_err, 1);
        checkOutput("cold_pcm_left_held", pcm_left, 20'h54321);

        flash_audio_reset_b = 1'b1;
        idleCycles(75);
        checkOutput("restart_bit_clk_en", bit_clk_en, 1);

        // Read 0x18 (back to default), then read 0x00
        applyStimulus(mkFrame(16'hC000, 20'h98000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("restart_tag", txCap[95:80], 16'h9800);
        checkOutput("restart_slot3", txCap[39:20], 20'h00000);
        applyStimulus(mkFrame(16'hC000, 20'h80000, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("rd18_dflt_tag", txCap[95:80], 16'hF800);
        checkOutput("rd18_dflt_slot1", txCap[79:60], 20'h18000);
        checkOutput("rd18_dflt_slot2", txCap[59:40], 20'h80000);
        checkOutput("restart_frame_cnt", frame_cnt, 1);
        applyStimulus(mkFrame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0), 255, 256);
        checkOutput("rd00_slot1", txCap[79:60], 20'h00000);
        checkOutput("rd00_slot2", txCap[59:40], 20'h00900);
        checkOutput("final_frame_cnt", frame_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
